// File: rtl/branch_resolve_btb.sv
// Jump/branch resolution unit with a direct-mapped branch target buffer.
// The fetch side gets a combinational prediction for f_pc. The execute side
// resolves JAL, JALR and the six conditional branches, and trains the BTB.
// A mispredict produces a registered redirect and opens a flush window for IF/ID.
module branch_resolve_btb #(
    parameter int XLEN         = 32,
    parameter int BTB_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    output logic [XLEN-1:0] f_pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [31:0]     ex_instr,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_addr,
    output logic            flush_stall,
    output logic [31:0]     mispredict_cnt
);
    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TW  = XLEN - IDX - 2;
    localparam int CW  = $clog2(FLUSH_CYCLES + 1);

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [BTB_ENTRIES-1:0] btb_jump;
    logic [TW-1:0]          btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target [BTB_ENTRIES];
    logic [1:0]             btb_cnt    [BTB_ENTRIES];

    logic [CW-1:0]   win_cnt;
    logic [IDX-1:0]  f_idx, e_idx;
    logic [TW-1:0]   f_tag, e_tag;
    logic            f_hit, e_hit;
    logic            is_jal, is_jalr, is_br, is_jump;
    logic            accept, cond, taken, mispredict;
    logic [XLEN-1:0] target, fix;

    assign f_idx = f_pc[IDX+1:2];
    assign f_tag = f_pc[XLEN-1:IDX+2];
    assign e_idx = ex_pc[IDX+1:2];
    assign e_tag = ex_pc[XLEN-1:IDX+2];

    // Fetch-side lookup; sees pre-edge BTB contents even when EX updates the same index
    assign f_hit         = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign f_pred_taken  = f_hit && (btb_jump[f_idx] || btb_cnt[f_idx][1]);
    assign f_pred_target = f_pred_taken ? btb_target[f_idx] : '0;

    assign e_hit       = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
    assign flush_stall = (win_cnt != '0);

    // Decode, compare and mispredict detection for the EX instruction
    always_comb begin
        is_jal  = (ex_instr[6:0] == 7'b1101111);
        is_jalr = (ex_instr[6:0] == 7'b1100111);
        is_br   = (ex_instr[6:0] == 7'b1100011) &&
                  (ex_instr[14:12] != 3'b010) && (ex_instr[14:12] != 3'b011);
        is_jump = is_jal || is_jalr;
        accept  = ex_valid && !flush_stall && (is_jump || is_br);
        case (ex_instr[14:12])
            3'b000:  cond = (ex_rs1 == ex_rs2);
            3'b001:  cond = (ex_rs1 != ex_rs2);
            3'b100:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  cond = (ex_rs1 <  ex_rs2);
            3'b111:  cond = (ex_rs1 >= ex_rs2);
            default: cond = 1'b0;
        endcase
        taken  = is_jump || cond;
        target = ex_pc + ex_imm;
        if (is_jalr) begin
            target = ex_rs1 + ex_imm;
            target[0] = 1'b0;
        end
        fix        = taken ? target : (ex_pc + XLEN'(4));
        mispredict = accept &&
                     ((taken != ex_pred_taken) || (taken && (ex_pred_target != target)));
    end

    // Redirect pulse, flush window down-counter and mispredict counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect       <= 1'b0;
            redirect_addr  <= '0;
            win_cnt        <= '0;
            mispredict_cnt <= '0;
        end else begin
            redirect <= mispredict;
            if (mispredict) begin
                redirect_addr  <= fix;
                win_cnt        <= CW'(FLUSH_CYCLES);
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end else if (win_cnt != '0) begin
                win_cnt <= win_cnt - CW'(1);
            end
        end
    end

    // BTB training on every accepted control instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid <= '0;
            btb_jump  <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_cnt[i]    <= '0;
            end
        end else if (accept) begin
            if (taken) begin
                btb_target[e_idx] <= target;
                btb_jump[e_idx]   <= is_jump;
                if (e_hit) begin
                    btb_cnt[e_idx] <= (btb_cnt[e_idx] == 2'b11) ? 2'b11 : btb_cnt[e_idx] + 2'd1;
                end else begin
                    btb_valid[e_idx] <= 1'b1;
                    btb_tag[e_idx]   <= e_tag;
                    btb_cnt[e_idx]   <= is_jump ? 2'b11 : 2'b10;
                end
            end else if (e_hit) begin
                btb_cnt[e_idx] <= (btb_cnt[e_idx] == 2'b00) ? 2'b00 : btb_cnt[e_idx] - 2'd1;
            end
        end
    end
endmodule
